sram_req_ctrl: RTL and testbench
================================

// Module: sram_req_ctrl
// PURPOSE
//   Upstream request controller for the 16-bit 1R1W SRAM macro of the swt16 core.
//   Arbitrates an instruction-fetch read port and a data read/write port onto
//   the macro's single read port and single write port; returns read data with
//   fixed 1-cycle latency. Optionally zero-fills the memory after reset.
//   Sits between the core's fetch/LSU stages and the SRAM macro.
// PARAMETERS
//   ADDR_W          12    word address width (macro ports are 12 bit)
//   DATA_W          16    data word width
//   DEPTH           1024  words cleared by the init sequence
//   CLEAR_ON_RESET  1     1: run CLEAR state after reset; 0: go straight to RUN
// PORTS
//   clk          in   1       single clock, all logic on posedge
//   rst          in   1       asynchronous, active-high reset
//   i_req_valid  in   1       fetch read request
//   i_req_ready  out  1       fetch request accepted this cycle (valid&ready)
//   i_addr       in   ADDR_W  fetch word address
//   i_rsp_valid  out  1       fetch read data valid (1-cycle pulse)
//   i_rsp_data   out  DATA_W  fetch read data
//   d_req_valid  in   1       data request
//   d_req_ready  out  1       data request accepted this cycle
//   d_we         in   1       1 = write, 0 = read
//   d_addr       in   ADDR_W  data word address
//   d_wdata      in   DATA_W  write data
//   d_rsp_valid  out  1       data read data valid (reads only, 1-cycle pulse)
//   d_rsp_data   out  DATA_W  data read data
//   mem_cs       out  1       macro chip select (active high)
//   mem_we       out  1       macro write enable (active high)
//   mem_wr_addr  out  ADDR_W  macro write address
//   mem_rd_addr  out  ADDR_W  macro read address
//   mem_wdata    out  DATA_W  macro write data
//   mem_rdata    in   DATA_W  macro read data, valid cycle after cs
//   init_done    out  1       high once in RUN
// BEHAVIOUR
//   - Reset: all outputs 0 (readies, rsp_valid, rsp_data, mem_*); state = CLEAR
//     with clr_cnt=0 if CLEAR_ON_RESET else RUN. Reset mid-operation aborts any
//     in-flight read (no rsp pulse) and restarts CLEAR from address 0.
//   - FSM CLEAR: both readies 0; mem_cs=mem_we=1, mem_wr_addr=clr_cnt, wdata=0,
//     clr_cnt++ each cycle; after writing DEPTH-1 -> RUN (DEPTH cycles total).
//   - FSM RUN: init_done=1; stays in RUN until reset.
//   - Ports are combinational grants: ready depends on valid/addr of same cycle.
//   - d write: always accepted in RUN (write port private to data side);
//     mem_we=1, mem_wr_addr=d_addr, mem_wdata=d_wdata same cycle.
//   - Reads share the one read port: i-read and d-read both valid -> round-robin
//     (1-bit last_grant, flips on each contended grant; reset favours data).
//     A d write and an i read issue together in one cycle.
//   - mem_cs = any read or write issued; mem_rd_addr holds last value when idle.
//   - Latency: request accepted in cycle N -> rsp_valid pulse + data in N+1.
//     No response backpressure; consumer must take it.
//   - Response data = mem_rdata in N+1; rsp_data registers hold value after.
//   - Hazard: i read of addr A in same cycle as d write to A (macro result
//     undefined): handled per CONFIGURATION.
//   - Addresses wrap naturally at 2^ADDR_W; no range check.
// CONFIGURATION
//   SRAM_FWD_EN defined: hazard read is accepted; write data is registered and
//     returned as i_rsp_data in N+1 (new data forwarded, zero stall).
//   SRAM_FWD_EN undefined: i_req_ready=0 in the hazard cycle (1-cycle stall);
//     read issues next cycle and returns the written data from the macro.
// TESTING
//   1 Reset, CLEAR_ON_RESET=1 -> init_done rises after exactly 1024 cycles;
//     readies 0 meanwhile; then read of addr 0x3FF -> rsp 0x0000.
//   2 d write 0x0012<=0xBEEF, then d read 0x0012 -> d_rsp_valid 1 cycle later,
//     data 0xBEEF; i_rsp_valid stays 0.
//   3 i read 0x010 and d read 0x020 held valid 4 cycles -> grants alternate
//     D,I,D,I; each rsp on correct port, 1-cycle latency.
//   4 d write 0x040<=0x1234 with i read 0x040 same cycle -> FWD_EN: rsp 0x1234
//     next cycle; no FWD_EN: i_req_ready=0, rsp 0x1234 two cycles later.
//   5 Assert rst mid-CLEAR (clr_cnt=500) and mid-read -> outputs 0 at once, no
//     rsp pulse, CLEAR restarts at 0 and takes 1024 cycles.
//   6 d write + unrelated i read same cycle -> both accepted, mem_we=1, cs=1.

Source files
------------

// File: rtl/sram_req_ctrl_if.sv
// sram_req_ctrl_if: bundles the core-side request/response handshakes and the
// SRAM macro bus for sram_req_ctrl. The controller uses the slave view; the
// environment (core stages plus macro) uses the master view.
interface sram_req_ctrl_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic              i_req_valid;
   logic              i_req_ready;
   logic [ADDR_W-1:0] i_addr;
   logic              i_rsp_valid;
   logic [DATA_W-1:0] i_rsp_data;
   logic              d_req_valid;
   logic              d_req_ready;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_rsp_valid;
   logic [DATA_W-1:0] d_rsp_data;
   logic              mem_cs;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              init_done;

   modport slave (
      input  i_req_valid, i_addr, d_req_valid, d_we, d_addr, d_wdata, mem_rdata,
      output i_req_ready, i_rsp_valid, i_rsp_data,
             d_req_ready, d_rsp_valid, d_rsp_data,
             mem_cs, mem_we, mem_wr_addr, mem_rd_addr, mem_wdata, init_done
   );

   modport master (
      output i_req_valid, i_addr, d_req_valid, d_we, d_addr, d_wdata, mem_rdata,
      input  i_req_ready, i_rsp_valid, i_rsp_data,
             d_req_ready, d_rsp_valid, d_rsp_data,
             mem_cs, mem_we, mem_wr_addr, mem_rd_addr, mem_wdata, init_done
   );
endinterface

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: upstream request controller for the swt16 16-bit 1R1W SRAM.
// Fetch (i) and data (d) requests share the macro's single read port with
// round-robin arbitration; the write port belongs to the data side alone.
// Read data returns exactly one cycle after acceptance. After reset the
// controller can zero-fill DEPTH words before opening the ports.
// Build option SRAM_FWD_EN: a fetch read that hits the address being written
// in the same cycle is accepted and answered with the new write data; without
// it that fetch read is stalled for one cycle.
module sram_req_ctrl #(
   parameter int ADDR_W         = 12,
   parameter int DATA_W         = 16,
   parameter int DEPTH          = 1024,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   sram_req_ctrl_if.slave bus
);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   localparam state_t            RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
   localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              prefer_d_q;
   logic              i_pend_q, d_pend_q;
   logic [DATA_W-1:0] i_data_q, d_data_q;
   logic [DATA_W-1:0] i_new;
   logic              i_go, d_go_rd, d_go_wr;
   logic              i_want, d_want_rd, hazard, flip;

`ifdef SRAM_FWD_EN
   logic              fwd_q;
   logic [DATA_W-1:0] fwd_data_q;

   // Capture write data for a same-address fetch read; the macro result is undefined then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         fwd_q <= i_go & hazard;
         if (i_go & hazard) fwd_data_q <= bus.d_wdata;
      end
   end

   assign i_new = fwd_q ? fwd_data_q : bus.mem_rdata;
`else
   assign i_new = bus.mem_rdata;
`endif

   // State register; reset restarts the clear sequence from address 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RST_STATE;
      else     state_q <= state_d;
   end

   // Next state, grants and macro controls; everything is forced low while reset is held.
   always_comb begin
      state_d          = state_q;
      i_go             = 1'b0;
      d_go_rd          = 1'b0;
      d_go_wr          = 1'b0;
      i_want           = 1'b0;
      d_want_rd        = 1'b0;
      hazard           = 1'b0;
      flip             = 1'b0;
      bus.i_req_ready  = 1'b0;
      bus.d_req_ready  = 1'b0;
      bus.mem_cs       = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_wr_addr  = '0;
      bus.mem_wdata    = '0;
      bus.mem_rd_addr  = rd_addr_q;
      if (!rst) begin
         case (state_q)
            ST_CLEAR: begin
               bus.mem_cs      = 1'b1;
               bus.mem_we      = 1'b1;
               bus.mem_wr_addr = clr_cnt_q;
               if (clr_cnt_q == CLR_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
               d_go_wr   = bus.d_req_valid & bus.d_we;
               d_want_rd = bus.d_req_valid & ~bus.d_we;
               hazard    = bus.i_req_valid & d_go_wr & (bus.i_addr == bus.d_addr);
               i_want    = bus.i_req_valid;
`ifndef SRAM_FWD_EN
               if (hazard) i_want = 1'b0;
`endif
               // Both reads want the single read port: alternate, data side first.
               if (i_want && d_want_rd) begin
                  flip    = 1'b1;
                  d_go_rd = prefer_d_q;
                  i_go    = ~prefer_d_q;
               end else begin
                  d_go_rd = d_want_rd;
                  i_go    = i_want;
               end
               bus.i_req_ready = i_go;
               bus.d_req_ready = d_go_rd | d_go_wr;
               bus.mem_cs      = i_go | d_go_rd | d_go_wr;
               bus.mem_we      = d_go_wr;
               if (d_go_wr) begin
                  bus.mem_wr_addr = bus.d_addr;
                  bus.mem_wdata   = bus.d_wdata;
               end
               if (i_go)         bus.mem_rd_addr = bus.i_addr;
               else if (d_go_rd) bus.mem_rd_addr = bus.d_addr;
            end
            default: state_d = RST_STATE;
         endcase
      end
   end

   // Clear address counter; only advances while clearing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      clr_cnt_q <= '0;
      else if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
   end

   // Round-robin pointer and held read address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prefer_d_q <= 1'b1;
         rd_addr_q  <= '0;
      end else begin
         if (flip) prefer_d_q <= ~prefer_d_q;
         rd_addr_q <= bus.mem_rd_addr;
      end
   end

   // Response pulses one cycle after acceptance; data registers keep the last answer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_pend_q <= 1'b0;
         d_pend_q <= 1'b0;
         i_data_q <= '0;
         d_data_q <= '0;
      end else begin
         i_pend_q <= i_go;
         d_pend_q <= d_go_rd;
         if (i_pend_q) i_data_q <= i_new;
         if (d_pend_q) d_data_q <= bus.mem_rdata;
      end
   end

   assign bus.i_rsp_valid = i_pend_q;
   assign bus.d_rsp_valid = d_pend_q;
   assign bus.i_rsp_data  = i_pend_q ? i_new : i_data_q;
   assign bus.d_rsp_data  = d_pend_q ? bus.mem_rdata : d_data_q;
   assign bus.init_done   = (state_q == ST_RUN) & ~rst;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: self-checking bench for sram_req_ctrl. Contains a simple
// 1R1W macro model and a word-level reference model of the memory contents,
// grant rules and response timing.
`timescale 1ns/1ps
module tb_sram_req_ctrl;
   localparam int AW    = 12;
   localparam int DW    = 16;
   localparam int DEPTH = 1024;
`ifdef SRAM_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fill_junk = 1'b1;
   always #5 clk = ~clk;

   sram_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [DW-1:0] junk(input int k);
      return DW'((k * 37) ^ 32'h0000C3A5);
   endfunction

   // Macro model: synchronous write, registered read of the old contents.
   logic [DW-1:0] sram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (fill_junk) begin
         for (int k = 0; k < (1<<AW); k++) sram[k] <= junk(k);
      end else if (bus.mem_cs) begin
         if (bus.mem_we) sram[bus.mem_wr_addr] <= bus.mem_wdata;
         bus.mem_rdata <= sram[bus.mem_rd_addr];
      end
   end

   int checks = 0;
   int failures = 0;

   // Reference model state.
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic          turn_d;
   logic          exp_iv, exp_dv;
   logic [DW-1:0] exp_id, exp_dd, held_id, held_dd;
   logic [AW-1:0] last_rd;
   // Last sampled DUT values for explicit checks.
   logic          smp_iv, smp_dv, smp_ir, smp_dr;
   logic [DW-1:0] smp_id, smp_dd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      turn_d  = 1'b1;
      exp_iv  = 1'b0;
      exp_dv  = 1'b0;
      held_id = '0;
      held_dd = '0;
      last_rd = '0;
   endtask

   task automatic set_idle();
      bus.i_req_valid = 1'b0;
      bus.i_addr      = '0;
      bus.d_req_valid = 1'b0;
      bus.d_we        = 1'b0;
      bus.d_addr      = '0;
      bus.d_wdata     = '0;
   endtask

   // One bus cycle: check last cycle's responses, drive, check grants against the model.
   task automatic cyc(input logic iv, input logic [AW-1:0] ia, input logic dv, input logic dwe,
                      input logic [AW-1:0] da, input logic [DW-1:0] dwd);
      logic hz, ie, drd, cont, e_ir, e_dr;
      @(negedge clk);
      smp_iv = bus.i_rsp_valid;
      smp_id = bus.i_rsp_data;
      smp_dv = bus.d_rsp_valid;
      smp_dd = bus.d_rsp_data;
      if (exp_iv) held_id = exp_id;
      if (exp_dv) held_dd = exp_dd;
      chk("i_rsp_valid", smp_iv, exp_iv);
      chk("i_rsp_data", smp_id, held_id);
      chk("d_rsp_valid", smp_dv, exp_dv);
      chk("d_rsp_data", smp_dd, held_dd);
      bus.i_req_valid = iv;
      bus.i_addr      = ia;
      bus.d_req_valid = dv;
      bus.d_we        = dwe;
      bus.d_addr      = da;
      bus.d_wdata     = dwd;
      #1;
      smp_ir = bus.i_req_ready;
      smp_dr = bus.d_req_ready;
      hz   = iv && dv && dwe && (ia == da);
      ie   = iv && (FWD || !hz);
      drd  = dv && !dwe;
      cont = ie && drd;
      e_dr = dv && (dwe || !cont || turn_d);
      e_ir = ie && (!cont || !turn_d);
      if (cont) turn_d = !turn_d;
      chk("i_req_ready", smp_ir, e_ir);
      chk("d_req_ready", smp_dr, e_dr);
      chk("mem_we", bus.mem_we, dv && dwe);
      chk("mem_cs", bus.mem_cs, e_ir || e_dr);
      if (dv && dwe) begin
         chk("mem_wr_addr", bus.mem_wr_addr, da);
         chk("mem_wdata", bus.mem_wdata, dwd);
      end
      if (e_ir)                  last_rd = ia;
      else if (e_dr && drd)      last_rd = da;
      chk("mem_rd_addr", bus.mem_rd_addr, last_rd);
      exp_iv = e_ir;
      exp_id = hz ? dwd : ref_mem[ia];
      exp_dv = e_dr && drd;
      exp_dd = ref_mem[da];
      if (dv && dwe) ref_mem[da] = dwd;
   endtask

   // Release reset and watch the clear sequence; stop_at>0 re-asserts reset mid-clear.
   task automatic run_clear(input string tag, input int stop_at);
      int n, bad, lim;
      model_reset();
      bus.i_req_valid = 1'b1;
      bus.i_addr      = 12'h3FF;
      bus.d_req_valid = 1'b1;
      bus.d_we        = 1'b1;
      bus.d_addr      = 12'h3FF;
      bus.d_wdata     = 16'hFFFF;
      @(negedge clk);
      rst = 1'b0;
      n   = 0;
      bad = 0;
      lim = (stop_at > 0) ? stop_at : 3000;
      #1;
      while (!bus.init_done && n < lim) begin
         if (bus.i_req_ready || bus.d_req_ready || !bus.mem_cs || !bus.mem_we ||
             bus.mem_wr_addr != AW'(n) || bus.mem_wdata != '0 ||
             bus.i_rsp_valid || bus.d_rsp_valid) bad++;
         @(posedge clk);
         n++;
         #1;
      end
      chk({tag, " clear_outputs"}, bad, 0);
      if (stop_at > 0) begin
         chk({tag, " clear_addr_at_stop"}, bus.mem_wr_addr, stop_at);
         rst = 1'b1;
         #1;
         chk({tag, " rst_mem_cs"}, bus.mem_cs, 0);
         chk({tag, " rst_mem_we_addr"}, {bus.mem_we, bus.mem_wr_addr}, 0);
         chk({tag, " rst_readies"}, {bus.i_req_ready, bus.d_req_ready, bus.init_done}, 0);
      end else begin
         chk({tag, " clear_cycles"}, n, DEPTH);
         for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
      end
      set_idle();
   endtask

   typedef struct {
      logic          iv;
      logic [AW-1:0] ia;
      logic          dv;
      logic          dwe;
      logic [AW-1:0] da;
      logic [DW-1:0] dwd;
      logic          e_ir;
      logic          e_dr;
      logic          e_we;
      logic          e_cs;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pat_d, pat_i;
      logic       riv, rdv, rwe;
      logic [AW-1:0] ria, rda;
      // Vectors applied after clear, outside any contended read pair.
      tbl[0] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 12'h100, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h101, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h102, 16'hCAFE, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{1'b1, 12'h056, 1'b1, 1'b1, 12'h055, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 12'h077, 1'b1, 1'b1, 12'h077, 16'h7777, FWD,  1'b1, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 12'hFFF, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'hFFF, 16'h0F0F, 1'b0, 1'b1, 1'b1, 1'b1};

      for (int k = 0; k < (1<<AW); k++) ref_mem[k] = junk(k);
      model_reset();
      set_idle();
      bus.i_req_valid = 1'b1;
      bus.d_req_valid = 1'b1;
      bus.d_we        = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      fill_junk = 1'b0;
      #1;
      // Reset state with requests pending.
      chk("reset readies", {bus.i_req_ready, bus.d_req_ready}, 0);
      chk("reset rsp", {bus.i_rsp_valid, bus.d_rsp_valid, bus.i_rsp_data, bus.d_rsp_data}, 0);
      chk("reset mem", {bus.mem_cs, bus.mem_we, bus.mem_wr_addr, bus.mem_rd_addr}, 0);
      chk("reset init_done", bus.init_done, 0);

      run_clear("por", 0);

      // Cleared top word reads back as zero.
      cyc(1'b1, 12'h3FF, 1'b0, 1'b0, 12'h000, 16'h0);
      cyc(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0);
      chk("t1 rsp valid", smp_iv, 1);
      chk("t1 rsp data", smp_id, 16'h0000);

      // Data write then read.
      cyc(1'b0, 12'h000, 1'b1, 1'b1, 12'h012, 16'hBEEF);
      cyc(1'b0, 12'h000, 1'b1, 1'b0, 12'h012, 16'h0);
      cyc(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0);
      chk("t2 d rsp", {smp_dv, smp_iv, smp_dd}, {1'b1, 1'b0, 16'hBEEF});
      cyc(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0);
      chk("t2 d hold", {smp_dv, smp_dd}, {1'b0, 16'hBEEF});

      // Contended reads alternate D,I,D,I.
      cyc(1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 16'h1111);
      cyc(1'b0, 12'h000, 1'b1, 1'b1, 12'h020, 16'h2222);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 16'h0);
         pat_d[k] = smp_dr;
         pat_i[k] = smp_ir;
      end
      cyc(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0);
      chk("t3 d grants", pat_d, 4'b0101);
      chk("t3 i grants", pat_i, 4'b1010);

      // Same-address write and fetch read.
      cyc(1'b1, 12'h040, 1'b1, 1'b1, 12'h040, 16'h1234);
`ifdef SRAM_FWD_EN
      chk("t4 hazard i_ready", smp_ir, 1);
      cyc(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0);
      chk("t4 fwd rsp", {smp_iv, smp_id}, {1'b1, 16'h1234});
`else
      chk("t4 hazard i_ready", smp_ir, 0);
      cyc(1'b1, 12'h040, 1'b0, 1'b0, 12'h000, 16'h0);
      chk("t4 retry i_ready", {smp_ir, smp_iv}, {1'b1, 1'b0});
      cyc(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0);
      chk("t4 stalled rsp", {smp_iv, smp_id}, {1'b1, 16'h1234});
`endif

      // Table vectors.
      for (int v = 0; v < 8; v++) begin
         cyc(tbl[v].iv, tbl[v].ia, tbl[v].dv, tbl[v].dwe, tbl[v].da, tbl[v].dwd);
         chk($sformatf("tbl%0d grants", v), {smp_ir, smp_dr}, {tbl[v].e_ir, tbl[v].e_dr});
         chk($sformatf("tbl%0d mem", v), {bus.mem_we, bus.mem_cs}, {tbl[v].e_we, tbl[v].e_cs});
      end

      // Randomized traffic on a small address pool to provoke hazards and reuse.
      for (int r = 0; r < 400; r++) begin
         riv = 1'($urandom_range(0, 1));
         rdv = 1'($urandom_range(0, 1));
         rwe = 1'($urandom_range(0, 1));
         ria = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         rda = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         cyc(riv, ria, rdv, rwe, rda, DW'($urandom));
      end
      cyc(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0);

      // Reset while a read is being granted: no response may appear.
      cyc(1'b1, 12'h010, 1'b1, 1'b1, 12'h099, 16'h7777);
      rst = 1'b1;
      #1;
      chk("t5 rst readies", {bus.i_req_ready, bus.d_req_ready}, 0);
      chk("t5 rst mem", {bus.mem_cs, bus.mem_we}, 0);
      @(posedge clk);
      #1;
      chk("t5 no rsp", {bus.i_rsp_valid, bus.d_rsp_valid, bus.i_rsp_data, bus.d_rsp_data}, 0);
      run_clear("rst_read", 0);

      // Reset mid-clear at 500, then a full clear must wipe address 500 too.
      cyc(1'b0, 12'h000, 1'b1, 1'b1, 12'h1F4, 16'hAAAA);
      cyc(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0);
      rst = 1'b1;
      #1;
      run_clear("mid", 500);
      run_clear("restart", 0);
      cyc(1'b0, 12'h000, 1'b1, 1'b0, 12'h1F4, 16'h0);
      cyc(1'b1, 12'h3FF, 1'b0, 1'b0, 12'h000, 16'h0);
      chk("t5 d rsp after restart", {smp_dv, smp_dd}, {1'b1, 16'h0000});
      cyc(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0);
      chk("t5 i rsp after restart", {smp_iv, smp_id}, {1'b1, 16'h0000});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
